mcfifo_mem: RTL
===============

# mcfifo_mem

Single-clock, multi-channel FIFO buffer: one shared dual-port memory partitioned into `1<<CHSIZE` independent circular queues of `1<<ADDRSIZE` words each. Each channel has its own pointers and full/empty flags. Reads are registered, and sticky overflow/underflow error flags are provided. It succeeds the single-queue RTL memory model and serves as the per-channel staging buffer wherever several streams share one clock domain.

## Interface
Parameters:
- `DATASIZE`, 8, data word width
- `ADDRSIZE`, 4, per-channel address bits; per-channel depth `DEPTH = 1<<ADDRSIZE`
- `CHSIZE`, 2, channel-select bits; channel count `NCH = 1<<CHSIZE`; total memory `NCH*DEPTH` words

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wdata`  in  DATASIZE  write word
- `wch`  in  CHSIZE  write channel select
- `winc`  in  1  write request
- `rch`  in  CHSIZE  read channel select
- `rinc`  in  1  read request
- `rdata`  out  DATASIZE  registered read word
- `rvalid`  out  1  `rdata` carries a newly popped word this cycle
- `wfull`  out  NCH  per-channel full flag, bit i = channel i
- `rempty`  out  NCH  per-channel empty flag
- `wovf`  out  1  sticky: write attempted to a full channel
- `rudf`  out  1  sticky: read attempted from an empty channel

## Operation
- Per channel i, keep `wptr[i]` and `rptr[i]`, each ADDRSIZE+1 bits binary. The MSB is the wrap bit.
- Flags are combinational from the pointers:
  - `rempty[i] = (wptr[i] == rptr[i])`
  - `wfull[i] = (wptr[i] == {~rptr[i][MSB], rptr[i][ADDRSIZE-1:0]})`
- Write accept: `winc && !wfull[wch]`.
  - Memory word `{wch, wptr[wch][ADDRSIZE-1:0]}` <= `wdata`.
  - `wptr[wch]` increments, wrapping modulo `2*DEPTH`.
- Read accept: `rinc && !rempty[rch]`.
  - `rdata` <= memory word `{rch, rptr[rch][ADDRSIZE-1:0]}`.
  - `rptr[rch]` increments.
  - `rvalid` <= 1.
- A cycle with no accepted read gives `rvalid` <= 0. `rdata` holds its last value.
- Rejected write (`winc && wfull[wch]`): memory and pointers are unchanged, and `wovf` <= 1.
- Rejected read (`rinc && rempty[rch]`): pointers and `rdata` are unchanged, `rvalid` <= 0, and `rudf` <= 1.
- `wovf` and `rudf` clear only on reset.
- Simultaneous read and write:
  - Acceptance of each uses the flags as they stand before the edge.
  - Same channel, empty: the write is accepted, the read is rejected (no bypass), and `rudf` is set.
  - Same channel, full: the read is accepted, the write is rejected, and `wovf` is set.
  - Same channel, neither full nor empty: both are accepted and the occupancy is unchanged.
  - Different channels: fully independent.
- Channels never affect each other's pointers, flags or storage.

## Timing
- Reset (asynchronous assert, effective immediately):
  - all pointers = 0, `rempty` = all ones, `wfull` = 0
  - `rdata` = 0, `rvalid` = 0, `wovf` = 0, `rudf` = 0
  - Memory contents are not reset.
- Reset mid-operation discards all queued data. The first write after release is stored at channel offset 0.
- Write-to-flag latency: 1 cycle. After an accepted write to an empty channel, `rempty[ch]` falls after the same edge.
- Read latency: 1 cycle. For a read accepted at edge N, `rdata`/`rvalid` are valid after edge N. `rempty`/`wfull` update after the same edge.
- Back-to-back reads on consecutive cycles give one word per cycle, with `rvalid` held high.
- Wrap-around: the pointer offset returns to 0 after `DEPTH` accesses. The wrap bit toggles, so full and empty stay distinguishable.
- Maximum occupancy per channel is exactly `DEPTH`.

## Test plan
- **Reset values:** assert `rst` mid-clock -> all outputs take their reset values immediately (`rempty=4'hF`, `wfull=0`, `rdata=0`, `rvalid=0`, `wovf=0`, `rudf=0`), with no clock edge required.
- **Fill channel 0:** write 0x00..0x0F to channel 0 -> `wfull[0]=1` after the 16th write. A 17th write (0xAA) sets `wovf=1`. Draining channel 0 then returns 0x00..0x0F, one per cycle with `rvalid=1`, no 0xAA, and `rempty[0]=1` after the last read.
- **Channel independence:** write 0x10,0x11 to ch1 and 0x30 to ch3 -> read ch3 returns 0x30. Reading ch1 twice returns 0x10 then 0x11. `rempty` returns to 4'hF. Channels 0 and 2 stay empty throughout.
- **Simultaneous read and write:**
  - ch2 holding one word 0x55, with read ch2 and write 0x66 to ch2 in the same cycle -> `rdata=0x55`, and ch2 then holds exactly 0x66.
  - ch2 empty, with read+write in the same cycle -> `rudf=1`, `rvalid=0`, and 0x66 is stored.
- **Wrap-around:** 40 interleaved write/read pairs on ch1 with incrementing data 0x00..0x27 -> data is returned in order with no loss, flags are correct across both pointer wraps, and `wovf=rudf=0`.
- **Reset mid-stream:** with 5 words queued in ch0 and a read in flight, assert `rst` -> `rvalid=0` immediately and `rempty[0]=1`. A new write of 0x77 followed by a read returns 0x77.

Source files
------------

// File: rtl/mcfifo_mem_if.sv
// Handshake bundle for the multi-channel FIFO: write/read requests with channel
// selects on one side, registered read data, per-channel flags and sticky errors on the other.
interface mcfifo_mem_if #(
   parameter int DATASIZE = 8,
   parameter int CHSIZE   = 2
);
   localparam int NCH = 1 << CHSIZE;

   logic [DATASIZE-1:0] wdata;
   logic [CHSIZE-1:0]   wch;
   logic                winc;
   logic [CHSIZE-1:0]   rch;
   logic                rinc;
   logic [DATASIZE-1:0] rdata;
   logic                rvalid;
   logic [NCH-1:0]      wfull;
   logic [NCH-1:0]      rempty;
   logic                wovf;
   logic                rudf;

   modport master (
      output wdata, wch, winc, rch, rinc,
      input  rdata, rvalid, wfull, rempty, wovf, rudf
   );

   modport slave (
      input  wdata, wch, winc, rch, rinc,
      output rdata, rvalid, wfull, rempty, wovf, rudf
   );
endinterface

// File: rtl/mcfifo_mem.sv
// Multi-channel FIFO: one shared memory split into NCH circular queues of DEPTH words,
// each with its own wrap-bit pointers, plus a registered read port and sticky error flags.
module mcfifo_mem #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4,
   parameter int CHSIZE   = 2
) (
   input logic         clk,
   input logic         rst,
   mcfifo_mem_if.slave bus
);
   localparam int NCH   = 1 << CHSIZE;
   localparam int DEPTH = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] PTR_ONE = (ADDRSIZE+1)'(1);

   logic [ADDRSIZE:0]          wptr_q [NCH];
   logic [ADDRSIZE:0]          wptr_d [NCH];
   logic [ADDRSIZE:0]          rptr_q [NCH];
   logic [ADDRSIZE:0]          rptr_d [NCH];
   logic [DATASIZE-1:0]        mem_q  [NCH*DEPTH];
   logic [DATASIZE-1:0]        rdata_q, rdata_d;
   logic                       rvalid_q, rvalid_d;
   logic                       wovf_q, wovf_d;
   logic                       rudf_q, rudf_d;
   logic [NCH-1:0]             wfull;
   logic [NCH-1:0]             rempty;
   logic                       wr_en, rd_en;
   logic [CHSIZE+ADDRSIZE-1:0] waddr, raddr;

   // Equal pointers mean empty; equal offsets with opposite wrap bits mean full.
   always_comb begin
      wfull  = '0;
      rempty = '0;
      for (int i = 0; i < NCH; i++) begin
         rempty[i] = (wptr_q[i] == rptr_q[i]);
         wfull[i]  = (wptr_q[i] == {~rptr_q[i][ADDRSIZE], rptr_q[i][ADDRSIZE-1:0]});
      end
   end

   always_comb begin
      wr_en    = bus.winc && !wfull[bus.wch];
      rd_en    = bus.rinc && !rempty[bus.rch];
      waddr    = {bus.wch, wptr_q[bus.wch][ADDRSIZE-1:0]};
      raddr    = {bus.rch, rptr_q[bus.rch][ADDRSIZE-1:0]};
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      if (wr_en) wptr_d[bus.wch] = wptr_q[bus.wch] + PTR_ONE;
      if (rd_en) rptr_d[bus.rch] = rptr_q[bus.rch] + PTR_ONE;
      rdata_d  = rd_en ? mem_q[raddr] : rdata_q;
      rvalid_d = rd_en;
      wovf_d   = wovf_q || (bus.winc && wfull[bus.wch]);
      rudf_d   = rudf_q || (bus.rinc && rempty[bus.rch]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
         end
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         wovf_q   <= 1'b0;
         rudf_q   <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         wovf_q   <= wovf_d;
         rudf_q   <= rudf_d;
      end
   end

   // Storage is deliberately left out of reset; stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[waddr] <= bus.wdata;
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign bus.wfull  = wfull;
   assign bus.rempty = rempty;
   assign bus.wovf   = wovf_q;
   assign bus.rudf   = rudf_q;
endmodule
